// File: rtl/texture_buffer.sv
// Four-port replicated texel store for the TMU quad read, loaded from an AXI-Stream upload.
// Optional macro TEXTURE_BUFFER_DOUBLE_BUFFER_EN adds a second page so reads never see a partial upload.
module texture_buffer #(
  parameter int PIXEL_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 17,
  parameter int STREAM_WIDTH = 64
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic [ADDR_WIDTH-1:0]   texelAddr00,
  input  logic [ADDR_WIDTH-1:0]   texelAddr01,
  input  logic [ADDR_WIDTH-1:0]   texelAddr10,
  input  logic [ADDR_WIDTH-1:0]   texelAddr11,
  output logic [PIXEL_WIDTH-1:0]  texelOutput00,
  output logic [PIXEL_WIDTH-1:0]  texelOutput01,
  output logic [PIXEL_WIDTH-1:0]  texelOutput10,
  output logic [PIXEL_WIDTH-1:0]  texelOutput11,
  output logic                    loadDone,
  output logic                    overflow
);

  localparam int N     = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int LOG_N = $clog2(N);
  localparam int BW    = (LOG_N > 0) ? LOG_N : 1;
  localparam int RW    = ADDR_WIDTH - LOG_N;
`ifdef TEXTURE_BUFFER_DOUBLE_BUFFER_EN
  localparam int PAGE_BITS = 1;
`else
  localparam int PAGE_BITS = 0;
`endif
  localparam int RIW  = RW + PAGE_BITS;
  localparam int ROWS = 2 ** RIW;
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(N);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH:0]    ptr_q;
  logic                   load_done_q;
  logic                   overflow_q;
  logic                   beat_acc;
  logic                   commit_start;
  logic                   wr_en;
  logic [RIW-1:0]         wr_row;
  logic [ADDR_WIDTH-1:0]  rd_addr [4];
  logic [BW-1:0]          rd_bank [4];
  logic [RIW-1:0]         rd_row  [4];
  logic [PIXEL_WIDTH-1:0] rd_q    [4];
  // Texel address a lives in bank a%N, row a/N, so one beat fills one row of every bank.
  logic [PIXEL_WIDTH-1:0] mem_q [4][N][ROWS];

  function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    return BW'(a % N);
  endfunction

  // NOTE: ready is gated by resetn combinationally so it is already low in the cycle reset is held.
  assign s_axis_tready = resetn && (state_q != COMMIT);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign commit_start  = beat_acc && s_axis_tlast;
  assign wr_en         = beat_acc && !ptr_q[ADDR_WIDTH];

  assign rd_addr[0] = texelAddr00;
  assign rd_addr[1] = texelAddr01;
  assign rd_addr[2] = texelAddr10;
  assign rd_addr[3] = texelAddr11;

`ifdef TEXTURE_BUFFER_DOUBLE_BUFFER_EN
  logic active_page_q;

  // Toggling on entry to COMMIT makes the read sampled at the end of COMMIT see the new page.
  always_ff @(posedge aclk) begin
    if (!resetn) active_page_q <= 1'b0;
    else if (commit_start) active_page_q <= ~active_page_q;
  end

  assign wr_row = {~active_page_q, ptr_q[ADDR_WIDTH-1:LOG_N]};

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_bank[p] = bank_of(rd_addr[p]);
      rd_row[p]  = {active_page_q, rd_addr[p][ADDR_WIDTH-1:LOG_N]};
    end
  end
`else
  assign wr_row = ptr_q[ADDR_WIDTH-1:LOG_N];

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_bank[p] = bank_of(rd_addr[p]);
      rd_row[p]  = rd_addr[p][ADDR_WIDTH-1:LOG_N];
    end
  end
`endif

  // NOTE: state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      load_done_q <= commit_start;
      case (state_q)
        IDLE: begin
          if (beat_acc) begin
            overflow_q <= 1'b0;
            ptr_q      <= ptr_q + STEP;
            state_q    <= s_axis_tlast ? COMMIT : LOAD;
          end
        end
        LOAD: begin
          if (beat_acc) begin
            // Saturate the pointer so an oversize upload can never wrap onto low addresses.
            if (ptr_q[ADDR_WIDTH]) overflow_q <= 1'b1;
            else                   ptr_q      <= ptr_q + STEP;
            if (s_axis_tlast) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          ptr_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the texel arrays are deliberately not reset so they map onto plain RAM.
  always_ff @(posedge aclk) begin
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < N; b++) begin
        if (wr_en) mem_q[r][b][wr_row] <= s_axis_tdata[b*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      for (int p = 0; p < 4; p++) rd_q[p] <= '0;
    end else begin
      for (int p = 0; p < 4; p++) rd_q[p] <= mem_q[p][rd_bank[p]][rd_row[p]];
    end
  end

  assign texelOutput00 = rd_q[0];
  assign texelOutput01 = rd_q[1];
  assign texelOutput10 = rd_q[2];
  assign texelOutput11 = rd_q[3];
  assign loadDone      = load_done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_texture_buffer.sv
// Scoreboard bench for texture_buffer: read expectations are queued at issue and checked by a monitor.
module tb_texture_buffer;

  localparam int PW = 32;
  localparam int AW = 4;
  localparam int SW = 64;

  typedef logic [3:0][PW-1:0] quad_t;

  logic          aclk    = 1'b0;
  logic          resetn  = 1'b0;
  logic          tvalid  = 1'b0;
  logic          tlast   = 1'b0;
  logic [SW-1:0] tdata   = '0;
  logic          tready;
  logic [AW-1:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
  logic [PW-1:0] o00, o01, o10, o11;
  logic          load_done, ovf;

  int    total    = 0;
  int    bad      = 0;
  int    ld_count = 0;
  int    ld_exp   = 0;
  logic  req_vld  = 1'b0;
  logic  rsp_vld  = 1'b0;
  quad_t exp_q[$];
  quad_t mon_e;

  always #5 aclk = ~aclk;

  texture_buffer #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .STREAM_WIDTH(SW)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .texelAddr00(a00), .texelAddr01(a01), .texelAddr10(a10), .texelAddr11(a11),
    .texelOutput00(o00), .texelOutput01(o01), .texelOutput10(o10), .texelOutput11(o11),
    .loadDone(load_done), .overflow(ovf)
  );

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge aclk) rsp_vld <= req_vld;
  always @(negedge aclk) if (load_done === 1'b1) ld_count++;

  always @(negedge aclk) begin
    if (rsp_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_underflow: got a response with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        check("rd00", o00, mon_e[0]);
        check("rd01", o01, mon_e[1]);
        check("rd10", o10, mon_e[2]);
        check("rd11", o11, mon_e[3]);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] x0, x1, x2, x3, input logic [PW-1:0] e0, e1, e2, e3);
    a00 = x0; a01 = x1; a10 = x2; a11 = x3;
    req_vld = 1'b1;
    exp_q.push_back({e3, e2, e1, e0});
  endtask

  task automatic rd_cycle(input logic [AW-1:0] x0, x1, x2, x3, input logic [PW-1:0] e0, e1, e2, e3);
    rd(x0, x1, x2, x3, e0, e1, e2, e3);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input logic last);
    tvalid = 1'b1; tdata = d; tlast = last;
    for (int i = 0; i < 20 && !tready; i++) tick();
    if (!tready) check("beat_ready_timeout", 32'(tready), 32'd1);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 check("tready_in_reset", 32'(tready), 32'd0);
    tick();
    check("rst_o00", o00, '0);
    check("rst_o01", o01, '0);
    check("rst_o10", o10, '0);
    check("rst_o11", o11, '0);
    check("rst_loaddone", 32'(load_done), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    resetn = 1'b1;
    #1 check("tready_after_reset", 32'(tready), 32'd1);

    // Two-beat upload, COMMIT handshake, quad read
    send_beat({32'h0000_0002, 32'h0000_0001}, 1'b0);
    check("tready_load", 32'(tready), 32'd1);
    send_beat({32'h0000_0004, 32'h0000_0003}, 1'b1);
    ld_exp++;
    check("tready_commit", 32'(tready), 32'd0);
    check("loaddone_commit", 32'(load_done), 32'd1);
    tick();
    check("tready_post_commit", 32'(tready), 32'd1);
    check("loaddone_one_cycle", 32'(load_done), 32'd0);
    check("loaddone_count_t1", 32'(ld_count), 32'(ld_exp));
    rd_cycle(0, 1, 2, 3, 32'h1, 32'h2, 32'h3, 32'h4);

    // Upload with tvalid toggling 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      send_beat({32'h11 + 32'(2*i) + 32'h1, 32'h11 + 32'(2*i)}, i == 3);
      if (i != 3) tick();
    end
    ld_exp++;
    tick();
    check("loaddone_count_t2", 32'(ld_count), 32'(ld_exp));
    rd_cycle(0, 1, 2, 3, 32'h11, 32'h12, 32'h13, 32'h14);
    rd_cycle(4, 5, 6, 7, 32'h15, 32'h16, 32'h17, 32'h18);

    // Oversize upload: 9 beats into 16 words
    for (int i = 0; i < 9; i++) begin
      if (i == 8) send_beat({32'hDEAD_0001, 32'hDEAD_0000}, 1'b1);
      else        send_beat({32'h100 + 32'(2*i) + 32'h1, 32'h100 + 32'(2*i)}, 1'b0);
      if (i == 7) check("overflow_before_beat8", 32'(ovf), 32'd0);
    end
    ld_exp++;
    check("overflow_after_beat8", 32'(ovf), 32'd1);
    check("loaddone_overflow", 32'(load_done), 32'd1);
    tick();
    check("overflow_sticky", 32'(ovf), 32'd1);
    check("loaddone_count_t3", 32'(ld_count), 32'(ld_exp));
    rd_cycle(0, 1, 14, 15, 32'h100, 32'h101, 32'h10E, 32'h10F);

    // Equal addresses, then distinct, each held three cycles
    rd(5, 5, 5, 5, 32'h105, 32'h105, 32'h105, 32'h105);
    tick();
    rd(5, 5, 5, 5, 32'h105, 32'h105, 32'h105, 32'h105);
    tick();
    rd(5, 5, 5, 5, 32'h105, 32'h105, 32'h105, 32'h105);
    tick();
    rd(5, 6, 7, 8, 32'h105, 32'h106, 32'h107, 32'h108);
    tick();
    rd(5, 6, 7, 8, 32'h105, 32'h106, 32'h107, 32'h108);
    tick();
    rd(5, 6, 7, 8, 32'h105, 32'h106, 32'h107, 32'h108);
    tick();
    req_vld = 1'b0;

    // First beat of the next upload clears overflow
    send_beat({32'h301, 32'h300}, 1'b1);
    ld_exp++;
    check("overflow_cleared", 32'(ovf), 32'd0);
    tick();

    // Reset in the middle of a three-beat upload
    send_beat({32'h202, 32'h201}, 1'b0);
    tvalid = 1'b1; tdata = {32'h204, 32'h203}; tlast = 1'b0;
    resetn = 1'b0;
    #1 check("tready_mid_reset", 32'(tready), 32'd0);
    tick();
    resetn = 1'b1; tvalid = 1'b0;
    #1 check("tready_after_mid_reset", 32'(tready), 32'd1);
    tick(); tick(); tick();
    check("no_loaddone_on_abort", 32'(ld_count), 32'(ld_exp));

    // Fresh single-beat upload lands at address 0
    tvalid = 1'b1; tdata = {32'h402, 32'h401}; tlast = 1'b1;
`ifndef TEXTURE_BUFFER_DOUBLE_BUFFER_EN
    rd(0, 0, 1, 1, 32'h201, 32'h201, 32'h202, 32'h202);
`endif
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    ld_exp++;
    check("loaddone_fresh", 32'(load_done), 32'd1);
    rd_cycle(0, 1, 2, 3, 32'h401, 32'h402, 32'h102, 32'h103);
    check("loaddone_count_t4", 32'(ld_count), 32'(ld_exp));

`ifdef TEXTURE_BUFFER_DOUBLE_BUFFER_EN
    // Texture A committed, then reads stay on A while B streams in
    send_beat({32'hAAAA_AAAA, 32'hAAAA_AAAA}, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = {32'hBBBB_BBBB, 32'hBBBB_BBBB}; tlast = (i == 2);
      rd(0, 0, 1, 1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    rd_cycle(0, 0, 1, 1, 32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB);
`endif

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
